bp_bht_arbiter: RTL and testbench
=================================

// Module: bp_bht_arbiter
// PURPOSE
// - Owns the single-port BHT RAM of the dynamic branch predictor (gshare, 2-bit counters). Shares it between FU lookups and EXU-BU updates.
// - Lookups normally win; EXU-BU updates are queued and drained as read-modify-write (RMW) when the port is free.
// - Starvation and queue-full conditions force update priority. Also sweep-initialises the BHT after reset.
// PARAMETERS
// - BHT_IDW   8      BHT index width; the BHT has 2**BHT_IDW entries.
// - GHRW      8      GHR width; must satisfy GHRW <= BHT_IDW.
// - BPCW      BHT_IDW+2  width of the PC slice used for indexing.
// - QDEPTH    4      update queue depth (power of 2).
// - MAX_WAIT  8      cycles a non-empty queue may be starved before update priority is forced.
// - CNT_INIT  2'b01  counter value written by the reset sweep (weakly not-taken).
// PORTS
// - clk          in   1        clock
// - aresetn      in   1        asynchronous reset, active-low
// - i_lkp_req    in   1        FU lookup request; held by FU while o_lkp_stall=1
// - i_lkp_pc     in   BPCW     lookup PC slice
// - i_lkp_ghr    in   GHRW     lookup GHR
// - o_lkp_stall  out  1        lookup not accepted this cycle
// - o_lkp_valid  out  1        lookup result valid (1 cycle after acceptance)
// - o_lkp_taken  out  1        prediction = counter[1]
// - i_upd_bht    in   1        update pulse from EXU-BU
// - i_upd_pc     in   BPCW     update PC slice
// - i_upd_ghr    in   GHRW     update GHR snapshot
// - i_upd_btaken in   1        resolved branch outcome
// - o_upd_drop   out  1        pulse: update discarded because the queue was full
// - o_busy       out  1        initialisation sweep in progress
// - o_ram_en, o_ram_we  out  1  RAM enable / write enable
// - o_ram_addr   out  BHT_IDW  RAM address
// - o_ram_wdata  out  2        RAM write data
// - i_ram_rdata  in   2        RAM read data, valid 1 cycle after a read
// - `ifdef PQR5_BHT_PERF_EN: o_perf_upd_cnt out 32, o_perf_stall_cnt out 32, o_perf_drop_cnt out 32
// BEHAVIOUR
// - Index: idx = pc[BPCW-1:2] ^ {zero-extended ghr}. Identical for lookups and updates.
// - Reset values: all outputs 0 except o_busy=1 and o_lkp_stall=1. Queue empty, wait counter 0, FSM in INIT.
// - INIT: writes CNT_INIT to address 0..2**BHT_IDW-1, one address per cycle.
//   o_busy=1 and o_lkp_stall=1 throughout; updates are queued but not drained.
//   Moves to IDLE the cycle after the last address is written.
// - Reset asserted mid-operation (any state): aborts, restarts the sweep at address 0, and clears the queue.
// - FSM states: INIT, IDLE, RD_WAIT, WR_PEND.
//   - IDLE, queue non-empty, port granted to update: issue RMW read, pop the queue head, go to RD_WAIT.
//   - RD_WAIT: i_ram_rdata is valid. Register the new counter: sat+1 if taken, sat-1 if not (saturate at 3 / 0).
//     If the port is granted this cycle, write it combinationally and go to IDLE; else go to WR_PEND.
//   - WR_PEND: write the registered counter when the port is granted, then go to IDLE.
// - Port grant: a lookup wins unless force=1. force = (wait counter == MAX_WAIT) | queue full.
//   - Once force triggers, the read and write of that RMW both win; this stalls lookups for 2 consecutive cycles.
//   - Wait counter: +1 per cycle while the queue is non-empty and no RMW phase is granted; cleared on any RMW write.
// - Lookup accepted at cycle t (i_lkp_req & !o_lkp_stall): o_lkp_valid=1 at t+1 with o_lkp_taken=rdata[1]; otherwise o_lkp_valid=0.
// - A lookup accepted between the RMW read and write of the same index returns the pre-update value. This is by design.
// - Queue push and pop in the same cycle are allowed, including when the queue is full.
//   A push into a full queue with no simultaneous pop is discarded; o_upd_drop pulses for 1 cycle.
// - Only one RMW is in flight at a time; updates are applied in arrival order.
// CONFIGURATION
// - PQR5_BHT_PERF_EN defined: three 32-bit wrapping counters, all reset to 0.
//   - o_perf_upd_cnt: RMW writes completed.
//   - o_perf_stall_cnt: cycles with i_lkp_req & o_lkp_stall.
//   - o_perf_drop_cnt: dropped updates.
// - PQR5_BHT_PERF_EN undefined: the counters and their ports are absent; all other behaviour is identical.
// STRUCTURE
// - pqr5_core_pkg:
//   - typedef bht_cnt_t (logic [1:0]).
//   - typedef struct bht_upd_t {idx, btaken}.
//   - enum bht_arb_state_t {INIT, IDLE, RD_WAIT, WR_PEND}.
//   - function bht_sat_upd(bht_cnt_t, logic).
// - Sub-module bht_upd_fifo: QDEPTH x bht_upd_t, push/pop/full/empty. This module contains the FSM, grant logic, index hash and sweep counter.
// TESTING
// - Reset, BHT_IDW=8: 256 writes of 2'b01 to addresses 0..255, then o_busy=0; a lookup to any index returns taken=0.
// - Two taken updates to pc=0x010, ghr=0x00 (idx 0x04), lookups idle: RAM[4] goes 01->10->11; a later lookup returns taken=1.
//   One further not-taken update gives RAM[4]=10.
// - Continuous i_lkp_req plus a single update: lookups win for 8 cycles, then o_lkp_stall=1 for exactly 2 cycles while the RMW runs.
// - Continuous lookups plus 5 back-to-back updates (QDEPTH=4): 5th push while full with no pop -> o_upd_drop=1.
//   Forced drain of the queued updates follows.
// - Pulse aresetn low during the sweep at address 100: sweep restarts at 0, queue empty, o_busy=1.
// - PQR5_BHT_PERF_EN defined: the scenarios above yield exact upd/stall/drop counts (e.g. drop_cnt=1 after the overflow test).

Source files
------------

// File: rtl/pqr5_core_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : pqr5_core_pkg                                                     |
// | Brief  : Shared BHT types, arbiter state encoding and counter helper.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package pqr5_core_pkg;

  // Index width carried by a queued update; BHT_IDW of the arbiter must not exceed it.
  localparam int unsigned BHT_UPD_IDW = 8;

  typedef logic [1:0] bht_cnt_t;

  typedef struct packed {
    logic [BHT_UPD_IDW-1:0] idx;
    logic                   btaken;
  } bht_upd_t;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    RD_WAIT = 2'd2,
    WR_PEND = 2'd3
  } bht_arb_state_t;

  function automatic bht_cnt_t bht_sat_upd(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) res = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bht_upd_fifo.sv
// +----------------------------------------------------------------------------+
// | Module : bht_upd_fifo                                                      |
// | Brief  : QDEPTH-entry queue of pending BHT updates; push+pop when full ok. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module bht_upd_fifo
  import pqr5_core_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic     clk,
  input  logic     aresetn,
  input  logic     push_i,
  input  bht_upd_t data_i,
  input  logic     pop_i,
  output bht_upd_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  bht_upd_t        mem_q [QDEPTH];
  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [PTRW:0]   cnt_q, cnt_d;
  logic            w_pop;
  logic            w_push;

  assign full_o  = (cnt_q == (PTRW+1)'(QDEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];

  // A pop frees the head slot in the same cycle, so a full queue still accepts a push.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (w_push) wptr_d = wptr_q + 1'b1;
    if (w_pop)  rptr_d = rptr_q + 1'b1;
    if (w_push && !w_pop)      cnt_d = cnt_q + 1'b1;
    else if (!w_push && w_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/bp_bht_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module : bp_bht_arbiter                                                    |
// | Brief  : Single-port gshare BHT owner: lookups vs queued RMW updates, with |
// |          post-reset sweep init. Optional perf counters: PQR5_BHT_PERF_EN.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module bp_bht_arbiter
  import pqr5_core_pkg::*;
#(
  parameter int unsigned BHT_IDW  = 8,
  parameter int unsigned GHRW     = 8,
  parameter int unsigned BPCW     = BHT_IDW + 2,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned MAX_WAIT = 8,
  parameter bht_cnt_t    CNT_INIT = 2'b01
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               i_lkp_req,
  input  logic [BPCW-1:0]    i_lkp_pc,
  input  logic [GHRW-1:0]    i_lkp_ghr,
  output logic               o_lkp_stall,
  output logic               o_lkp_valid,
  output logic               o_lkp_taken,
  input  logic               i_upd_bht,
  input  logic [BPCW-1:0]    i_upd_pc,
  input  logic [GHRW-1:0]    i_upd_ghr,
  input  logic               i_upd_btaken,
  output logic               o_upd_drop,
`ifdef PQR5_BHT_PERF_EN
  output logic [31:0]        o_perf_upd_cnt,
  output logic [31:0]        o_perf_stall_cnt,
  output logic [31:0]        o_perf_drop_cnt,
`endif
  output logic               o_busy,
  output logic               o_ram_en,
  output logic               o_ram_we,
  output logic [BHT_IDW-1:0] o_ram_addr,
  output logic [1:0]         o_ram_wdata,
  input  logic [1:0]         i_ram_rdata
);

  localparam logic [1:0] ST_INIT    = 2'(INIT);
  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_RD_WAIT = 2'(RD_WAIT);
  localparam logic [1:0] ST_WR_PEND = 2'(WR_PEND);

  localparam int unsigned WAITW = $clog2(MAX_WAIT + 1);

  function automatic logic [BHT_IDW-1:0] hash_idx(input logic [BPCW-1:0] pc,
                                                  input logic [GHRW-1:0] ghr);
    return pc[BPCW-1:2] ^ BHT_IDW'(ghr);
  endfunction

  logic [1:0]         state_q, state_d;
  logic [BHT_IDW-1:0] sweep_q, sweep_d;
  logic [WAITW-1:0]   wait_q, wait_d;
  logic [BHT_IDW-1:0] cur_idx_q, cur_idx_d;
  logic               cur_tk_q, cur_tk_d;
  bht_cnt_t           cnt_q, cnt_d;
  logic               force_q, force_d;
  logic               lkp_valid_q;
  logic               drop_q;

  logic [BHT_IDW-1:0] w_lkp_idx;
  logic [BHT_IDW-1:0] w_head_idx;
  bht_upd_t           w_push_data;
  bht_upd_t           w_q_head;
  logic               w_q_full;
  logic               w_q_empty;
  logic               w_q_pop;
  logic               w_force;
  logic               w_rmw_rd;
  logic               w_rmw_wr;
  logic               w_lkp_acc;
  logic               w_drop;
  bht_cnt_t           w_new_cnt;
  bht_cnt_t           w_wdata;
  logic               w_unused_pc;

  assign w_lkp_idx          = hash_idx(i_lkp_pc, i_lkp_ghr);
  assign w_push_data.idx    = BHT_UPD_IDW'(hash_idx(i_upd_pc, i_upd_ghr));
  assign w_push_data.btaken = i_upd_btaken;
  assign w_head_idx         = BHT_IDW'(w_q_head.idx);
  assign w_unused_pc        = ^{i_lkp_pc[1:0], i_upd_pc[1:0]};

  bht_upd_fifo #(
    .QDEPTH (QDEPTH)
  ) u_upd_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .push_i  (i_upd_bht),
    .data_i  (w_push_data),
    .pop_i   (w_q_pop),
    .data_o  (w_q_head),
    .full_o  (w_q_full),
    .empty_o (w_q_empty)
  );

  assign w_force = (wait_q == WAITW'(MAX_WAIT)) | w_q_full;

  // force_q keeps a forced RMW forced through its write phase, so it costs lookups two adjacent cycles.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    cur_idx_d = cur_idx_q;
    cur_tk_d  = cur_tk_q;
    cnt_d     = cnt_q;
    force_d   = force_q;
    w_q_pop   = 1'b0;
    w_rmw_rd  = 1'b0;
    w_rmw_wr  = 1'b0;
    w_new_cnt = bht_sat_upd(i_ram_rdata, cur_tk_q);
    w_wdata   = cnt_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!w_q_empty && (!i_lkp_req || w_force)) begin
          w_rmw_rd  = 1'b1;
          w_q_pop   = 1'b1;
          cur_idx_d = w_head_idx;
          cur_tk_d  = w_q_head.btaken;
          force_d   = w_force;
          state_d   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (!i_lkp_req || force_q || w_force) begin
          w_rmw_wr = 1'b1;
          w_wdata  = w_new_cnt;
          force_d  = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d   = w_new_cnt;
          state_d = ST_WR_PEND;
        end
      end
      ST_WR_PEND: begin
        if (!i_lkp_req || w_force) begin
          w_rmw_wr = 1'b1;
          w_wdata  = cnt_q;
          force_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (w_rmw_wr) begin
      wait_d = '0;
    end else if (!w_q_empty && !w_rmw_rd && (wait_q != WAITW'(MAX_WAIT))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign o_busy      = (state_q == ST_INIT);
  assign o_lkp_stall = o_busy | w_rmw_rd | w_rmw_wr;
  assign w_lkp_acc   = i_lkp_req & ~o_lkp_stall;
  assign w_drop      = i_upd_bht & w_q_full & ~w_q_pop;

  // The port stays quiet while aresetn is low so the sweep never writes during reset.
  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = 2'b00;
    if (aresetn) begin
      if (o_busy) begin
        o_ram_en    = 1'b1;
        o_ram_we    = 1'b1;
        o_ram_addr  = sweep_q;
        o_ram_wdata = CNT_INIT;
      end else if (w_rmw_wr) begin
        o_ram_en    = 1'b1;
        o_ram_we    = 1'b1;
        o_ram_addr  = cur_idx_q;
        o_ram_wdata = w_wdata;
      end else if (w_rmw_rd) begin
        o_ram_en    = 1'b1;
        o_ram_addr  = w_head_idx;
      end else if (w_lkp_acc) begin
        o_ram_en    = 1'b1;
        o_ram_addr  = w_lkp_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      wait_q      <= '0;
      cur_idx_q   <= '0;
      cur_tk_q    <= 1'b0;
      cnt_q       <= 2'b00;
      force_q     <= 1'b0;
      lkp_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      wait_q      <= wait_d;
      cur_idx_q   <= cur_idx_d;
      cur_tk_q    <= cur_tk_d;
      cnt_q       <= cnt_d;
      force_q     <= force_d;
      lkp_valid_q <= w_lkp_acc;
      drop_q      <= w_drop;
    end
  end

  assign o_lkp_valid = lkp_valid_q;
  assign o_lkp_taken = lkp_valid_q & i_ram_rdata[1];
  assign o_upd_drop  = drop_q;

`ifdef PQR5_BHT_PERF_EN
  logic [31:0] perf_upd_q;
  logic [31:0] perf_stall_q;
  logic [31:0] perf_drop_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      perf_upd_q   <= '0;
      perf_stall_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (w_rmw_wr)                  perf_upd_q   <= perf_upd_q + 32'd1;
      if (i_lkp_req && o_lkp_stall)  perf_stall_q <= perf_stall_q + 32'd1;
      if (w_drop)                    perf_drop_q  <= perf_drop_q + 32'd1;
    end
  end

  assign o_perf_upd_cnt   = perf_upd_q;
  assign o_perf_stall_cnt = perf_stall_q;
  assign o_perf_drop_cnt  = perf_drop_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_bht_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module : tb_bp_bht_arbiter                                                 |
// | Brief  : Directed self-checking bench for bp_bht_arbiter with a RAM model. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_bp_bht_arbiter;

  localparam int NENT = 256;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       i_lkp_req = 1'b0;
  logic [9:0] i_lkp_pc = '0;
  logic [7:0] i_lkp_ghr = '0;
  logic       i_upd_bht = 1'b0;
  logic [9:0] i_upd_pc = '0;
  logic [7:0] i_upd_ghr = '0;
  logic       i_upd_btaken = 1'b0;
  logic       o_lkp_stall, o_lkp_valid, o_lkp_taken, o_upd_drop, o_busy;
  logic       o_ram_en, o_ram_we;
  logic [7:0] o_ram_addr;
  logic [1:0] o_ram_wdata;
  logic [1:0] ram_rdata_q;
`ifdef PQR5_BHT_PERF_EN
  logic [31:0] o_perf_upd_cnt, o_perf_stall_cnt, o_perf_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0] mem [NENT];

  bp_bht_arbiter dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .i_lkp_req    (i_lkp_req),
    .i_lkp_pc     (i_lkp_pc),
    .i_lkp_ghr    (i_lkp_ghr),
    .o_lkp_stall  (o_lkp_stall),
    .o_lkp_valid  (o_lkp_valid),
    .o_lkp_taken  (o_lkp_taken),
    .i_upd_bht    (i_upd_bht),
    .i_upd_pc     (i_upd_pc),
    .i_upd_ghr    (i_upd_ghr),
    .i_upd_btaken (i_upd_btaken),
    .o_upd_drop   (o_upd_drop),
`ifdef PQR5_BHT_PERF_EN
    .o_perf_upd_cnt   (o_perf_upd_cnt),
    .o_perf_stall_cnt (o_perf_stall_cnt),
    .o_perf_drop_cnt  (o_perf_drop_cnt),
`endif
    .o_busy       (o_busy),
    .o_ram_en     (o_ram_en),
    .o_ram_we     (o_ram_we),
    .o_ram_addr   (o_ram_addr),
    .o_ram_wdata  (o_ram_wdata),
    .i_ram_rdata  (ram_rdata_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_ram_en) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      ram_rdata_q <= mem[o_ram_addr];
    end
  end

  task automatic test_reset;
    int bad;
    bad = 0;
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_lkp_stall, o_lkp_valid, o_lkp_taken, o_upd_drop, o_ram_en, o_ram_we} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 1100000",
               {o_busy, o_lkp_stall, o_lkp_valid, o_lkp_taken, o_upd_drop, o_ram_en, o_ram_we});
    end
    aresetn = 1'b1;
    for (int i = 0; i < NENT; i++) begin
      #1;
      if (!(o_ram_en && o_ram_we && o_ram_addr == 8'(i) && o_ram_wdata == 2'b01 && o_busy && o_lkp_stall))
        bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_sequence: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_done_busy: got %b expected 0", o_busy);
    end
    bad = 0;
    for (int k = 0; k < NENT; k++) if (mem[k] !== 2'b01) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_ram_contents: got %0d entries not 01 expected 0", bad);
    end
  endtask

  task automatic do_lookup(input logic [9:0] pc, input logic [7:0] ghr, input logic exp_tk, input string name);
    @(posedge clk); #1;
    i_lkp_req = 1'b1; i_lkp_pc = pc; i_lkp_ghr = ghr;
    @(negedge clk);
    checks++;
    if (o_lkp_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: got stall=%b expected 0", name, o_lkp_stall);
    end
    @(posedge clk); #1;
    i_lkp_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_lkp_valid, o_lkp_taken} !== {1'b1, exp_tk}) begin
      errors++;
      $display("FAIL %s_result: got valid/taken=%b expected %b", name, {o_lkp_valid, o_lkp_taken}, {1'b1, exp_tk});
    end
  endtask

  task automatic push_upd(input logic [9:0] pc, input logic [7:0] ghr, input logic tk);
    i_upd_bht = 1'b1; i_upd_pc = pc; i_upd_ghr = ghr; i_upd_btaken = tk;
  endtask

  task automatic test_lookup_init;
    do_lookup(10'h3A4, 8'h5C, 1'b0, "lkp_after_init");
  endtask

  task automatic test_update_sat;
    @(posedge clk); #1;
    push_upd(10'h010, 8'h00, 1'b1);
    @(posedge clk); #1;
    push_upd(10'h010, 8'h00, 1'b1);
    @(posedge clk); #1;
    i_upd_bht = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem[4] !== 2'b10) begin
      errors++;
      $display("FAIL sat_first: got %b expected 10", mem[4]);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem[4] !== 2'b11) begin
      errors++;
      $display("FAIL sat_second: got %b expected 11", mem[4]);
    end
    do_lookup(10'h010, 8'h00, 1'b1, "lkp_idx4_pc");
    do_lookup(10'h000, 8'h04, 1'b1, "lkp_idx4_ghr");
    do_lookup(10'h010, 8'h01, 1'b0, "lkp_idx5");
    @(posedge clk); #1;
    push_upd(10'h010, 8'h00, 1'b0);
    @(posedge clk); #1;
    i_upd_bht = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (mem[4] !== 2'b10) begin
      errors++;
      $display("FAIL sat_not_taken: got %b expected 10", mem[4]);
    end
  endtask

  task automatic test_lookup_stall;
    logic [13:0] stall_v;
    logic [13:0] valid_v;
    @(posedge clk); #1;
    i_lkp_req = 1'b1; i_lkp_pc = 10'h100; i_lkp_ghr = 8'h00;
    push_upd(10'h020, 8'h00, 1'b1);
    @(negedge clk);
    checks++;
    if (o_lkp_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_push_cycle: got %b expected 0", o_lkp_stall);
    end
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      i_upd_bht = 1'b0;
      @(negedge clk);
      stall_v[k] = o_lkp_stall;
      valid_v[k] = o_lkp_valid;
    end
    @(posedge clk); #1;
    i_lkp_req = 1'b0;
    checks++;
    if (stall_v !== 14'h0300) begin
      errors++;
      $display("FAIL stall_pattern: got %h expected 0300", stall_v);
    end
    checks++;
    if (valid_v !== 14'h39FF) begin
      errors++;
      $display("FAIL valid_pattern: got %h expected 39ff", valid_v);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mem[8] !== 2'b10) begin
      errors++;
      $display("FAIL stall_rmw_result: got %b expected 10", mem[8]);
    end
  endtask

  task automatic test_mid_reset;
    logic found;
    int   writes;
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;
    push_upd(10'h050, 8'h00, 1'b1);
    @(posedge clk); #1;
    push_upd(10'h050, 8'h00, 1'b1);
    @(posedge clk); #1;
    i_upd_bht = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (o_busy && o_ram_addr == 8'd100) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_reach_100: got timeout expected address 100");
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_lkp_stall, o_ram_en, o_ram_we} !== 4'b1100) begin
      errors++;
      $display("FAIL mid_reset_state: got %b expected 1100", {o_busy, o_lkp_stall, o_ram_en, o_ram_we});
    end
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_ram_en, o_ram_we, o_ram_addr} !== {3'b111, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset_restart: got busy/en/we=%b addr=%h expected 111 addr=00",
               {o_busy, o_ram_en, o_ram_we}, o_ram_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (!o_busy) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_sweep_done: got timeout expected o_busy=0");
    end
    writes = 0;
    for (int k = 0; k < 30; k++) begin
      if (o_ram_we) writes++;
      @(negedge clk);
    end
    checks++;
    if (writes != 0 || mem[20] !== 2'b01) begin
      errors++;
      $display("FAIL mid_reset_queue_cleared: got %0d writes mem20=%b expected 0 writes mem20=01", writes, mem[20]);
    end
  endtask

  task automatic test_overflow;
    logic [5:0] drop_v;
    logic       found;
    aresetn = 1'b0;
    i_lkp_req = 1'b1; i_lkp_pc = 10'h3FC; i_lkp_ghr = 8'h00;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      push_upd(10'((10 + k) * 4), 8'h00, 1'b1);
      @(negedge clk);
      drop_v[k] = o_upd_drop;
    end
    @(posedge clk); #1;
    i_upd_bht = 1'b0;
    @(negedge clk);
    drop_v[5] = o_upd_drop;
    checks++;
    if (drop_v !== 6'b100000) begin
      errors++;
      $display("FAIL overflow_drop_pulse: got %b expected 100000", drop_v);
    end
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      if (mem[13] === 2'b10) found = 1'b1;
    end
    @(posedge clk); #1;
    i_lkp_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL overflow_drain_timeout: got timeout expected mem13=10");
    end
    checks++;
    if ({mem[10], mem[11], mem[12], mem[13]} !== 8'b10101010) begin
      errors++;
      $display("FAIL overflow_drained: got %b expected 10101010", {mem[10], mem[11], mem[12], mem[13]});
    end
    checks++;
    if (mem[14] !== 2'b01) begin
      errors++;
      $display("FAIL overflow_dropped_entry: got %b expected 01", mem[14]);
    end
`ifdef PQR5_BHT_PERF_EN
    checks++;
    if (o_perf_drop_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_drop: got %0d expected 1", o_perf_drop_cnt);
    end
    checks++;
    if (o_perf_upd_cnt !== 32'd4) begin
      errors++;
      $display("FAIL perf_upd: got %0d expected 4", o_perf_upd_cnt);
    end
    checks++;
    if (o_perf_stall_cnt !== 32'd264) begin
      errors++;
      $display("FAIL perf_stall: got %0d expected 264", o_perf_stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lookup_init();
    test_update_sat();
    test_lookup_stall();
    test_mid_reset();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
